count_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the 4-bit up/down loadable counter (sync load LTn, direction Upn_down).

---
 rtl/count_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_count_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_ctrl
// Description : Command-driven sequencer for a 4-bit up/down loadable counter.
//               Each accepted command loads the counter, lets it count for N
//               clocks, then parks it by reloading the final value every
//               cycle. A shadow model of the counter flags any divergence
//               between the expected count and the counter's dout.
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_ctrl #(
  parameter int DW     = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_load,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              ctr_ltn,
  output logic              ctr_upn_down,
  output logic [DW-1:0]     ctr_load,
  input  logic [DW-1:0]     ctr_dout,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     done_val,
  output logic              done_abort,
  output logic              mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [STEP_W-1:0] remaining;
  logic [DW-1:0]     park;
  logic [DW-1:0]     shadow;
  logic [DW-1:0]     shadow_next;
  logic              chk_en;

  // Only IDLE can take a new command.
  assign cmd_ready = (state == IDLE);

  // Value the counter will hold after the coming edge, given what we drive it with.
  always_comb begin
    shadow_next = shadow;
    if (!ctr_ltn) begin
      shadow_next = ctr_load;
    end else if (ctr_upn_down) begin
      shadow_next = shadow - 1'b1;
    end else begin
      shadow_next = shadow + 1'b1;
    end
  end

  // Shadow copy of the counter, following the same load/step/wrap rules.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      shadow <= shadow_next;
    end
  end

  // Sticky divergence flag; the first cycle after reset is skipped because the
  // counter itself only becomes defined one edge after ctr_load is forced to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_en   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      chk_en <= 1'b1;
      if (chk_en && (ctr_dout != shadow)) begin
        mismatch <= 1'b1;
      end
    end
  end

  // Sequencer FSM with all counter controls and status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      remaining    <= '0;
      park         <= '0;
      ctr_ltn      <= 1'b0;
      ctr_load     <= '0;
      ctr_upn_down <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_val     <= '0;
      done_abort   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ctr_ltn <= 1'b0;
          if (cmd_valid) begin
            // Command fields are captured here only; later changes are ignored.
            state        <= LOAD;
            busy         <= 1'b1;
            ctr_load     <= cmd_load;
            ctr_upn_down <= cmd_dir;
            remaining    <= cmd_steps;
          end else begin
            ctr_load <= park;
          end
        end
        LOAD: begin
          // The load itself completes on this edge whatever happens next.
          if (abort || (remaining == '0)) begin
            state      <= DONE;
            done       <= 1'b1;
            done_val   <= ctr_load;
            done_abort <= abort;
            park       <= ctr_load;
          end else begin
            state   <= RUN;
            ctr_ltn <= 1'b1;
          end
        end
        RUN: begin
          // This edge always counts, so an abort lands on the post-edge value.
          remaining <= remaining - 1'b1;
          if (abort || (remaining == STEP_W'(1))) begin
            state      <= DONE;
            done       <= 1'b1;
            done_val   <= shadow_next;
            done_abort <= abort;
            park       <= shadow_next;
            ctr_ltn    <= 1'b0;
            ctr_load   <= shadow_next;
          end
        end
        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          ctr_ltn  <= 1'b0;
          ctr_load <= park;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_seq_ctrl
// Description : Self-checking bench for count_seq_ctrl with a behavioural
//               4-bit up/down loadable counter closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_load;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       abort;
  logic       ctr_ltn;
  logic       ctr_upn_down;
  logic [3:0] ctr_load;
  logic [3:0] ctr_dout;
  logic       busy;
  logic       done;
  logic [3:0] done_val;
  logic       done_abort;
  logic       mismatch;

  logic [3:0] ctr_q;
  logic       force_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] val;
    logic       ab;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] load;
    logic       dir;
    logic [7:0] steps;
    int         abort_at;   // -1 none, 0 during LOAD, k during k-th RUN cycle
    logic [3:0] exp_val;
    logic       exp_ab;
    int         exp_busy;
  } vec_t;
  vec_t vecs[8];

  count_seq_ctrl #(.DW(4), .STEP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_load     (cmd_load),
    .cmd_dir      (cmd_dir),
    .cmd_steps    (cmd_steps),
    .abort        (abort),
    .ctr_ltn      (ctr_ltn),
    .ctr_upn_down (ctr_upn_down),
    .ctr_load     (ctr_load),
    .ctr_dout     (ctr_dout),
    .busy         (busy),
    .done         (done),
    .done_val     (done_val),
    .done_abort   (done_abort),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  // Behavioural counter: synchronous load when LTn low, otherwise count.
  always @(posedge clk) begin
    if (!ctr_ltn)          ctr_q <= ctr_load;
    else if (ctr_upn_down) ctr_q <= ctr_q - 4'd1;
    else                   ctr_q <= ctr_q + 4'd1;
  end
  assign ctr_dout = force_err ? ~ctr_q : ctr_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_done_val"}, done_val, e.val);
      check({name, "_done_abort"}, done_abort, e.ab);
      check({name, "_dout_final"}, ctr_dout, e.val);
    end
  endtask

  // Issue one command at a negedge, follow it to its done pulse.
  task automatic run_cmd(input vec_t v, input bit abort_with_cmd);
    int         busy_cnt = 0;
    bit         got_done = 0;
    logic [3:0] exp_d;
    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_load = v.load; cmd_dir = v.dir; cmd_steps = v.steps;
    abort = abort_with_cmd;
    sb.push_back('{v.exp_val, v.exp_ab});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_load = ~v.load; cmd_dir = ~v.dir; cmd_steps = 8'd1; abort = 1'b0;
    for (int i = 1; i <= 400 && !got_done; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        pop_check("cmd");
        check("busy_cycles", busy_cnt, v.exp_busy);
        check("no_mismatch", mismatch, 0);
        got_done = 1;
        abort = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", {busy, cmd_ready}, 2'b01);
        check("done_val_held", done_val, v.exp_val);
        check("parked", ctr_dout, v.exp_val);
      end else begin
        if (i >= 2) begin
          exp_d = v.dir ? 4'(int'(v.load) - (i - 2)) : 4'(int'(v.load) + (i - 2));
          check("run_trace", ctr_dout, exp_d);
        end
        abort = (v.abort_at >= 0) && (i == v.abort_at + 1);
        @(negedge clk);
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int  nd;
    bit  drop;
    bit  seen_done;
    exp_t e;

    rst = 1'b1; cmd_valid = 1'b0; cmd_load = 4'h0; cmd_dir = 1'b0;
    cmd_steps = 8'd0; abort = 1'b0; force_err = 1'b0;

    vecs[0] = '{4'h3, 1'b0, 8'd4,   -1, 4'h7, 1'b0, 6};
    vecs[1] = '{4'h1, 1'b1, 8'd3,   -1, 4'hE, 1'b0, 5};
    vecs[2] = '{4'h9, 1'b0, 8'd0,   -1, 4'h9, 1'b0, 2};
    vecs[3] = '{4'h0, 1'b0, 8'd10,   3, 4'h3, 1'b1, 5};
    vecs[4] = '{4'hE, 1'b0, 8'd3,   -1, 4'h1, 1'b0, 5};
    vecs[5] = '{4'h5, 1'b1, 8'd21,  -1, 4'h0, 1'b0, 23};
    vecs[6] = '{4'h7, 1'b1, 8'd5,    0, 4'h7, 1'b1, 2};
    vecs[7] = '{4'hC, 1'b0, 8'd255, -1, 4'hB, 1'b0, 257};

    // Reset state and five idle cycles.
    do_reset();
    check("rst_outputs", {busy, done, done_val, done_abort, ctr_upn_down}, 8'h00);
    for (int c = 0; c < 5; c++) begin
      check("idle_dout", ctr_dout, 4'h0);
      @(negedge clk);
    end
    check("idle_ltn", ctr_ltn, 0);
    check("idle_load", ctr_load, 4'h0);
    check("idle_ready", cmd_ready, 1);
    check("idle_mismatch", mismatch, 0);

    // Table of commands.
    for (int k = 0; k < 8; k++) run_cmd(vecs[k], 1'b0);

    // cmd_valid together with abort in IDLE: abort ignored.
    run_cmd(vecs[0], 1'b1);

    // Back-to-back: second command held valid while busy must stall.
    cmd_valid = 1'b1; cmd_load = 4'h2; cmd_dir = 1'b0; cmd_steps = 8'd2;
    sb.push_back('{4'h4, 1'b0});
    @(negedge clk);
    cmd_load = 4'h8; cmd_dir = 1'b1; cmd_steps = 8'd1;
    sb.push_back('{4'h7, 1'b0});
    nd = 0;
    for (int i = 0; i < 40 && nd < 2; i++) begin
      drop = 0;
      if (busy) check("stall_ready", cmd_ready, 0);
      if (done) begin
        pop_check("b2b");
        nd++;
      end
      if (nd == 1 && cmd_ready && cmd_valid) drop = 1;
      @(negedge clk);
      if (drop) cmd_valid = 1'b0;
    end
    if (nd < 2) check("b2b_timeout", nd, 2);
    @(negedge clk);

    // Corrupt dout for one cycle mid-run; mismatch must set and stick.
    cmd_valid = 1'b1; cmd_load = 4'h5; cmd_dir = 1'b0; cmd_steps = 8'd6;
    sb.push_back('{4'hB, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mm_before", mismatch, 0);
    force_err = 1'b1;
    @(negedge clk);
    force_err = 1'b0;
    check("mm_set", mismatch, 1);
    seen_done = 0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (done) begin
        pop_check("mm_cmd");
        seen_done = 1;
      end
      @(negedge clk);
    end
    if (!seen_done) check("mm_done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check("mm_sticky", mismatch, 1);
    do_reset();
    check("mm_cleared", mismatch, 0);
    @(negedge clk);

    // Reset mid-run: command dropped, no done, counter back to 0.
    cmd_valid = 1'b1; cmd_load = 4'h4; cmd_dir = 1'b0; cmd_steps = 8'd8;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_state", {cmd_ready, busy, done, ctr_ltn, ctr_load}, 8'b1000_0000);
    @(negedge clk);
    check("midrun_dout_zero", ctr_dout, 4'h0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen_done = 1;
      @(negedge clk);
    end
    check("midrun_no_done", seen_done, 0);
    check("midrun_no_mismatch", mismatch, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
